// File: rtl/sync_frame_pkg.sv
// rtl/sync_frame_pkg.sv - shared state type, default sync pattern and index sizing for sync_frame_tx
package sync_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;

  // One counter serves all three phases, so it must reach the largest phase length minus one.
  function automatic int idx_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - payload shift register: parallel load, shift-left on enable, MSB out
module frame_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial framer: sync pattern, MSB-first payload, zero guard gap
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter int                GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int IDX_W = idx_width(SYNC_W, DATA_W, GAP_LEN);
  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_W - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_LEN - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bit_q, bit_d;
  logic              done_q, done_d;
  logic              ser_load, ser_shift, ser_msb;
  logic [SYNC_W-1:0] sync_rest;

  frame_serializer #(.DATA_W(DATA_W)) u_serializer (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .shift (ser_shift),
    .din   (tx_data),
    .msb   (ser_msb)
  );

  assign tx_ready   = (state_q == ST_IDLE) && !rst;
  assign tx_bit     = bit_q;
  assign tx_active  = (state_q != ST_IDLE);
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  // tx_bit is registered, so each branch loads the bit that will be on the line after the edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    sync_rest = SYNC_PAT << (idx_q + IDX_W'(1));
    case (state_q)
      ST_IDLE: begin
        bit_d = 1'b0;
        if (tx_valid && tx_ready) begin
          state_d  = ST_SYNC;
          idx_d    = '0;
          bit_d    = SYNC_PAT[SYNC_W-1];
          ser_load = 1'b1;
        end
      end
      ST_SYNC: begin
        if (bit_en) begin
          if (idx_q == SYNC_LAST) begin
            state_d   = ST_DATA;
            idx_d     = '0;
            bit_d     = ser_msb;
            ser_shift = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            bit_d = sync_rest[SYNC_W-1];
          end
        end
      end
      ST_DATA: begin
        if (bit_en) begin
          if (idx_q == DATA_LAST) begin
            state_d = ST_GAP;
            idx_d   = '0;
            bit_d   = 1'b0;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            bit_d     = ser_msb;
            ser_shift = 1'b1;
          end
        end
      end
      ST_GAP: begin
        bit_d = 1'b0;
        if (bit_en) begin
          if (idx_q == GAP_LAST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        bit_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - self-checking bench for sync_frame_tx against a frame-level bit model
module tb_sync_frame_tx;

  localparam int DATA_W     = 8;
  localparam int SYNC_W     = 4;
  localparam int GAP_LEN    = 2;
  localparam int FRAME_BITS = SYNC_W + DATA_W + GAP_LEN;
  localparam logic [3:0] PAT = 4'b1101;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_bit;
  logic       tx_active;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_frame_tx #(
    .DATA_W   (DATA_W),
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (PAT),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole frame as it should appear on the line, first bit at the MSB.
  function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [7:0] d);
    return {PAT, d, {GAP_LEN{1'b0}}};
  endfunction

  // Occurrences of 1101 in the line stream, with idle zeros ahead of the frame.
  function automatic int pattern_count(input logic [7:0] d);
    logic [FRAME_BITS+2:0] s;
    int n;
    n = 0;
    s = {3'b000, frame_bits(d)};
    for (int i = 0; i < FRAME_BITS; i++)
      if (4'(s >> i) == 4'b1101) n++;
    return n;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    bit_en   = 1'($urandom % 2);
    for (int i = 0; i < 64 && !tx_ready; i++) tick();
    check_val("ready_before_frame", 32'(tx_ready), 1);
    tick();
    tx_valid = 1'b0;
  endtask

  // Called the cycle after the handshake; checks every cycle of the frame and the end state.
  task automatic run_frame(input logic [7:0] d, input int period, input bit chain,
                           input logic [7:0] next_d, input bit det);
    logic [FRAME_BITS-1:0] exp;
    logic [3:0]            win;
    int                    hits;
    int                    hit_at;
    exp    = frame_bits(d);
    win    = 4'b0000;
    hits   = 0;
    hit_at = -1;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int c = 0; c < period; c++) begin
        if (c == 0) begin
          win = {win[2:0], tx_bit};
          if (win == 4'b1101) begin
            hits++;
            hit_at = k;
          end
        end
        check_val("tx_bit", 32'(tx_bit), 32'(exp[FRAME_BITS-1-k]));
        check_val("tx_active_busy", 32'(tx_active), 1);
        check_val("tx_ready_busy", 32'(tx_ready), 0);
        check_val("frame_done_early", 32'(frame_done), 0);
        bit_en   = (c == period - 1);
        tx_valid = chain ? 1'b1 : 1'($urandom % 2);
        tx_data  = chain ? next_d : 8'($urandom);
        tick();
      end
    end
    check_val("frame_done_pulse", 32'(frame_done), 1);
    check_val("tx_active_end", 32'(tx_active), 0);
    check_val("tx_ready_end", 32'(tx_ready), 1);
    check_val("tx_bit_idle", 32'(tx_bit), 0);
    if (det) begin
      check_val("det_hits", 32'(hits), 1);
      check_val("det_align", 32'(hit_at), 3);
    end
    if (!chain) begin
      tx_valid = 1'b0;
      tick();
      check_val("frame_done_once", 32'(frame_done), 0);
      check_val("tx_ready_idle", 32'(tx_ready), 1);
    end
  endtask

  initial begin
    logic [7:0] p;
    rst      = 1'b1;
    bit_en   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    tick();
    check_val("rst_tx_bit", 32'(tx_bit), 0);
    check_val("rst_tx_active", 32'(tx_active), 0);
    check_val("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    #1;
    check_val("rst_tx_ready", 32'(tx_ready), 1);

    // bit_en low freezes the line
    start_frame(8'h3C);
    bit_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("hold_tx_bit", 32'(tx_bit), 1);
      check_val("hold_active", 32'(tx_active), 1);
    end
    run_frame(8'h3C, 1, 1'b0, 8'h00, 1'b0);

    start_frame(8'hA5);
    run_frame(8'hA5, 1, 1'b0, 8'h00, 1'b0);

    start_frame(8'h0F);
    run_frame(8'h0F, 3, 1'b0, 8'h00, 1'b0);

    // Back-to-back with tx_valid held high
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    bit_en   = 1'b1;
    check_val("b2b_ready_first", 32'(tx_ready), 1);
    tick();
    run_frame(8'h81, 1, 1'b1, 8'h7E, 1'b0);
    tick();
    tx_valid = 1'b0;
    run_frame(8'h7E, 1, 1'b0, 8'h00, 1'b0);

    start_frame(8'hC3);
    run_frame(8'hC3, 2, 1'b0, 8'h00, 1'b0);

    // Reset while payload bit 3 is on the line
    start_frame(8'hB6);
    bit_en = 1'b1;
    for (int i = 0; i < SYNC_W + 3; i++) tick();
    check_val("abort_bit3", 32'(tx_bit), 32'(frame_bits(8'hB6)[FRAME_BITS-1-(SYNC_W+3)]));
    rst = 1'b1;
    tick();
    check_val("abort_tx_bit", 32'(tx_bit), 0);
    check_val("abort_active", 32'(tx_active), 0);
    check_val("abort_done", 32'(frame_done), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("abort_no_done", 32'(frame_done), 0);
      check_val("abort_idle", 32'(tx_active), 0);
    end
    start_frame(8'h55);
    run_frame(8'h55, 1, 1'b0, 8'h00, 1'b0);

    // Reset wins over a simultaneous handshake
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    tx_valid = 1'b0;
    check_val("rst_vs_hs_active", 32'(tx_active), 0);
    tick();
    check_val("rst_vs_hs_idle", 32'(tx_active), 0);

    // Detector loopback over payloads that do not alias the sync pattern
    for (int f = 0; f < 10; f++) begin
      p = 8'($urandom);
      for (int a = 0; a < 200 && pattern_count(p) != 1; a++) p = 8'($urandom);
      start_frame(p);
      run_frame(p, 1, 1'b0, 8'h00, 1'b1);
    end

    for (int f = 0; f < 6; f++) begin
      p = 8'($urandom);
      start_frame(p);
      run_frame(p, $urandom_range(1, 4), 1'b0, 8'h00, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
